// File: rtl/assoc_cache.sv
// Two-way set-associative write-back, write-allocate cache with LRU replacement.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module assoc_cache #(
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] access_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  logic [1:0]       state;
  logic [OFF_W-1:0] word_cnt;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;
  logic             victim;

  logic [31:0]      data_mem [2][SETS][BLOCK_WORDS];
  logic [TAG_W-1:0] tag_mem  [2][SETS];
  logic [SETS-1:0]  valid    [2];
  logic [SETS-1:0]  dirty    [2];
  logic [SETS-1:0]  lru;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req, hit0, hit1, hit, hit_way, is_idle, miss, new_victim, word_last;
  logic             unused_addr_bits;

  assign req_off = cpu_addr[OFF_W+1:2];
  assign req_idx = cpu_addr[OFF_W+2 +: IDX_W];
  assign req_tag = cpu_addr[31 -: TAG_W];
  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  assign req       = cpu_read | cpu_write;
  assign hit0      = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign hit1      = valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = ~hit0;
  assign is_idle   = (state == IDLE);
  assign miss      = is_idle & req & ~hit;
  assign cpu_stall = ~is_idle | (req & ~hit);
  assign cpu_rdata = (is_idle & req & hit) ? data_mem[hit_way][req_idx][req_off] : '0;
  assign word_last = (word_cnt == OFF_W'(BLOCK_WORDS - 1));

  // Invalid ways are filled before anything is evicted; way0 wins a tie.
  assign new_victim = !valid[0][req_idx] ? 1'b0 :
                      !valid[1][req_idx] ? 1'b1 : lru[req_idx];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      WRITEBACK: begin
        mem_addr  = {tag_mem[victim][miss_idx], miss_idx, word_cnt, 2'b00};
        mem_wdata = data_mem[victim][miss_idx][word_cnt];
        mem_write = 1'b1;
      end
      REFILL: begin
        mem_addr = {miss_tag, miss_idx, word_cnt, 2'b00};
        mem_read = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      victim   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            lru[req_idx] <= ~hit_way;
            if (cpu_write) begin
              data_mem[hit_way][req_idx][req_off] <= cpu_wdata;
              dirty[hit_way][req_idx]             <= 1'b1;
            end
          end else if (miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            victim   <= new_victim;
            word_cnt <= '0;
            state    <= (valid[new_victim][req_idx] && dirty[new_victim][req_idx]) ?
                        WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_last) begin
              dirty[victim][miss_idx] <= 1'b0;
              state                   <= REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            data_mem[victim][miss_idx][word_cnt] <= mem_rdata;
            word_cnt <= word_cnt + 1'b1;
            if (word_last) begin
              tag_mem[victim][miss_idx] <= miss_tag;
              valid[victim][miss_idx]   <= 1'b1;
              dirty[victim][miss_idx]   <= 1'b0;
              state                     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      access_count <= '0;
      miss_count   <= '0;
    end else begin
      if (req && !cpu_stall && access_count != '1) access_count <= access_count + 1'b1;
      if (miss && miss_count != '1)                miss_count   <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache (SETS=4, BLOCK_WORDS=4): directed scenarios plus
// random traffic checked against an MRU-ordered residency model and a flat memory image.
`timescale 1ns/1ps
module tb_assoc_cache;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, cpu_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] access_count, miss_count;
`endif

  assoc_cache #(.SETS(4), .BLOCK_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .access_count(access_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory and the CPU-visible golden image
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] gold    [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[15:0], 16'hC0DE} ^ 32'h1357_0000;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return mem_word(a);
  endfunction

  // Memory responder: acks after ack_delay waiting cycles, logs every acked word
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          rd_words  = 0;
  int          wr_words  = 0;
  logic [31:0] held_addr;
  logic        held_wr;
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  bit          log_wr   [$];

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        check("strobe_excl", mem_read & mem_write, 0);
        if (wait_cnt > 0) begin
          check("hold_addr", mem_addr, held_addr);
          check("hold_kind", mem_write, held_wr);
        end else begin
          held_addr = mem_addr;
          held_wr   = mem_write;
        end
        mem_rdata = mem_read ? mem_word(mem_addr) : '0;
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_write ? mem_wdata : mem_rdata);
          log_wr.push_back(mem_write);
          if (mem_write) begin
            mem_img[mem_addr] = mem_wdata;
            wr_words++;
          end else begin
            rd_words++;
          end
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Reference model: per set, resident tags ordered most-recently-used first
  logic [25:0] m_tag   [4][2];
  bit          m_dirty [4][2];
  int          m_n     [4];
  int          exp_acc, exp_miss;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_n[s] = 0;
    gold.delete();
    exp_acc  = 0;
    exp_miss = 0;
  endtask

  function automatic void model_access(input logic [31:0] a, input bit wr,
                                       output bit hit, output bit wb);
    int          s = int'(a[5:4]);
    logic [25:0] t = a[31:6];
    int          pos = -1;
    logic [25:0] tt;
    bit          dd;
    hit = 0;
    wb  = 0;
    for (int i = 0; i < m_n[s]; i++) if (m_tag[s][i] == t) pos = i;
    if (pos >= 0) begin
      hit = 1;
      if (pos == 1) begin
        tt = m_tag[s][0];   dd = m_dirty[s][0];
        m_tag[s][0] = m_tag[s][1]; m_dirty[s][0] = m_dirty[s][1];
        m_tag[s][1] = tt;   m_dirty[s][1] = dd;
      end
    end else begin
      if (m_n[s] == 2) wb = m_dirty[s][1];
      else m_n[s]++;
      m_tag[s][1] = m_tag[s][0]; m_dirty[s][1] = m_dirty[s][0];
      m_tag[s][0] = t;           m_dirty[s][0] = 0;
    end
    if (wr) m_dirty[s][0] = 1;
  endfunction

  // One CPU access; called at posedge+1, returns at posedge+1 after completion
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input bit rd, input bit wr);
    bit          hit, wb, done;
    int          exp_stall, stall, r0, w0;
    logic [31:0] exp_rd, got_rd;
    model_access(a, wr, hit, wb);
    exp_acc++;
    if (!hit) exp_miss++;
    exp_stall = hit ? 0 : 1 + (wb ? 8 : 4) * (ack_delay + 1);
    exp_rd    = gold_word(a);
    r0 = rd_words;
    w0 = wr_words;
    cpu_addr = a; cpu_wdata = wd; cpu_read = rd; cpu_write = wr;
    stall = 0;
    done  = 0;
    got_rd = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        got_rd = cpu_rdata;
        done   = 1;
        break;
      end
      stall++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_stall"}, stall, exp_stall);
    check({tag, "_rdwords"}, rd_words - r0, hit ? 0 : 4);
    check({tag, "_wrwords"}, wr_words - w0, wb ? 4 : 0);
    if (rd) check({tag, "_rdata"}, got_rd, exp_rd);
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (wr) gold[a] = wd;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_wr.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wb_exp [4];
    int          op, r0;
    bit          reached;

    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    mem_img[32'h100] = 32'hA0;
    mem_img[32'h104] = 32'hA1;
    mem_img[32'h108] = 32'hA2;
    mem_img[32'h10C] = 32'hA3;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold read miss, single-cycle acks
    ack_delay = 0;
    clear_log();
    access("rd100", 32'h100, '0, 1, 0);
    check("rd100_nlog", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check("rd100_addr", log_addr[i], 32'h100 + 32'(4 * i));
      check("rd100_kind", log_wr[i], 0);
    end

    // Write hit then read back
    access("wr104", 32'h104, 32'hDEADBEEF, 0, 1);
    access("rd104", 32'h104, '0, 1, 0);

    // Fill way1, hit it, then evict the dirty 0x100 line
    access("rd200a", 32'h200, '0, 1, 0);
    access("rd200b", 32'h200, '0, 1, 0);
    clear_log();
    access("rd300", 32'h300, '0, 1, 0);
    wb_exp[0] = 32'hA0; wb_exp[1] = 32'hDEADBEEF; wb_exp[2] = 32'hA2; wb_exp[3] = 32'hA3;
    check("evict_nlog", log_addr.size(), 8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      if (i < 4) begin
        check("wb_addr", log_addr[i], 32'h100 + 32'(4 * i));
        check("wb_data", log_data[i], wb_exp[i]);
        check("wb_kind", log_wr[i], 1);
      end else begin
        check("refill_addr", log_addr[i], 32'h300 + 32'(4 * (i - 4)));
        check("refill_kind", log_wr[i], 0);
      end
    end
`ifdef CACHE_STATS_EN
    check("stats_access", access_count, 6);
    check("stats_miss", miss_count, 3);
`endif

    // Slow memory: three wait cycles per word
    ack_delay = 3;
    access("slow410", 32'h410, '0, 1, 0);

    // Reset in the middle of a refill
    ack_delay = 0;
    r0 = rd_words;
    cpu_addr = 32'h100;
    cpu_read = 1'b1;
    reached  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_words - r0 >= 2) begin
        reached = 1;
        break;
      end
    end
    check("abort_reached", reached, 1);
    @(posedge clk); #1;
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_mem_read", mem_read, 0);
    check("abort_mem_write", mem_write, 0);
    check("abort_stall", cpu_stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    access("reread100", 32'h100, '0, 1, 0);

    // Random traffic over a small address pool to force conflicts and evictions
    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 20);
      ack_delay = int'($urandom_range(0, 2));
      op = int'($urandom_range(0, 3));
      case (op)
        0, 1: access("rnd_rd", a, '0, 1, 0);
        2:    access("rnd_wr", a, $urandom, 0, 1);
        default: access("rnd_rw", a, $urandom, 1, 1);
      endcase
    end
`ifdef CACHE_STATS_EN
    check("stats_access_end", access_count, 32'(exp_acc));
    check("stats_miss_end", miss_count, 32'(exp_miss));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 The block SHALL have parameter SETS, default 64, giving the number of sets (power of 2, >=2).
REQ-002 The block SHALL have parameter BLOCK_WORDS, default 4, giving 32-bit words per line (power of 2, >=2); associativity is fixed at 2 ways.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; reset reset, synchronous, active-high; clock clk.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have ports cpu_addr in 32, cpu_wdata in 32, cpu_read in 1, cpu_write in 1: the CPU request.
REQ-006 The block SHALL have ports cpu_rdata out 32 (read data) and cpu_stall out 1 (access not complete).
REQ-007 The block SHALL have ports mem_addr out 32, mem_wdata out 32, mem_read out 1 and mem_write out 1: the word request to memory.
REQ-008 The block SHALL have ports mem_rdata in 32 (read word) and mem_ack in 1 (current word done).

Function
REQ-009 Address split SHALL be: offset = cpu_addr[log2(BLOCK_WORDS)+1:2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-010 Per set: 2 ways of {valid, dirty, tag, data}, plus 1 LRU bit naming the least-recently-used way.
REQ-011 States SHALL be IDLE, WRITEBACK and REFILL.
REQ-012 Hit in IDLE: cpu_stall=0, cpu_rdata = hit word combinationally in the same cycle; LRU bit set to the other way.
REQ-013 Write hit: word updated at the clock edge, dirty set; read+write both high acts as a write and cpu_rdata shows the pre-write word.
REQ-014 Miss in IDLE: cpu_stall=1 combinationally; latch miss address; victim = first invalid way (way0 preferred), else LRU way; go to WRITEBACK if victim is valid and dirty, else REFILL.
REQ-015 WRITEBACK: words 0..BLOCK_WORDS-1 sent at {victim tag, index, word, 2'b00} with mem_write=1, then dirty cleared and go to REFILL.
REQ-016 REFILL: words fetched from {latched tag, index, word, 2'b00} with mem_read=1, then tag written, valid set, dirty cleared and go to IDLE, where the access completes as a hit (write-allocate).
REQ-017 Handshake: mem_addr, mem_wdata and strobes SHALL hold stable until mem_ack is sampled high; each ack advances the word counter by one; ack is legal in the same cycle the request is raised.
REQ-018 mem_read and mem_write SHALL never be high together; both are low in IDLE.
REQ-019 cpu_stall SHALL equal (state!=IDLE) OR (request AND miss); the CPU holds its request while stalled.
REQ-020 With no request, IDLE holds and no state changes.

Reset
REQ-021 Reset SHALL clear all valid, dirty and LRU bits and force state=IDLE and word counter=0.
REQ-022 Outputs after reset SHALL be: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, cpu_rdata=0 when idle, cpu_stall=0 with no request.
REQ-023 Reset mid-WRITEBACK or mid-REFILL SHALL abort the transfer, with strobes low the next cycle; dirty data is discarded and there is no flush.

Configuration
REQ-024 Macro CACHE_STATS_EN defined: outputs access_count and miss_count (32 bits each, reset 0, saturating at all-ones) are present; access_count increments on each completed access (request AND NOT cpu_stall); miss_count increments on each miss detection in IDLE.
REQ-025 Macro CACHE_STATS_EN undefined: the counter ports and logic are absent and all other behaviour is identical.

Verification (SETS=4, BLOCK_WORDS=4: offset [3:2], index [5:4], tag [31:6])
REQ-026 Reset, then read 0x100 with mem_ack every cycle and mem_rdata 0xA0..0xA3 -> mem_read at addresses 0x100, 0x104, 0x108, 0x10C; cpu_stall high 5 cycles; then cpu_rdata=0xA0 with stall low.
REQ-027 Write 0xDEADBEEF to 0x104, then read 0x104 -> no stall, no memory strobes, cpu_rdata=0xDEADBEEF.
REQ-028 Read 0x200 (miss, fills way1), read 0x200 (hit), read 0x300 -> victim is the 0x100 line; WRITEBACK of 0xA0, 0xDEADBEEF, 0xA2, 0xA3 to 0x100..0x10C, then REFILL from 0x300..0x30C.
REQ-029 mem_ack delayed 3 cycles per word -> mem_addr and mem_read stable across each wait; stall lasts 1+4x4 cycles.
REQ-030 Reset asserted after 2 REFILL acks -> next cycle strobes=0 and state=IDLE; a re-read of 0x100 misses again.
REQ-031 With CACHE_STATS_EN, run REQ-026..REQ-028 -> access_count=6, miss_count=3; without the macro, the same traffic results.
